// File: rtl/seat_alloc_sched.sv
// seat_alloc_sched: round-robin kiosk arbiter over a shared seat table with wall-clock expiry sweeps.
// Build macro SEAT_ALLOC_AUTO_EN enables op 10 (reserve the lowest-index free seat).
module seat_alloc_sched #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SEATS = 16,
  parameter int SEAT_W    = 4,
  parameter int HOLD_MIN  = 120
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [SEAT_W*NUM_REQ-1:0] req_seat,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [10:0]               time_in,
  input  logic                      rst_timer,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic                      rsp_ok,
  output logic [SEAT_W-1:0]         rsp_seat,
  output logic [NUM_SEATS-1:0]      seat_busy,
  output logic [SEAT_W:0]           free_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, EXEC = 2'd2, SWEEP = 2'd3} state_t;

  localparam logic [1:0]        OP_RES    = 2'b00;
  localparam logic [1:0]        OP_REL    = 2'b01;
  localparam logic [1:0]        OP_ANY    = 2'b10;
  localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_SEATS - 1);

  function automatic logic [10:0] expiry_of(input logic [10:0] now);
    logic [11:0] sum;
    sum = {1'b0, now} + 12'(HOLD_MIN);
    return (sum >= 12'd1440) ? 11'(sum - 12'd1440) : sum[10:0];
  endfunction

  function automatic logic [SEAT_W:0] free_of(input logic [NUM_SEATS-1:0] busy);
    logic [SEAT_W:0] used;
    used = '0;
    for (int i = 0; i < NUM_SEATS; i++) used = used + {{SEAT_W{1'b0}}, busy[i]};
    return (SEAT_W+1)'(NUM_SEATS) - used;
  endfunction

  state_t                state_r, state_n;
  logic [10:0]           now_min_r;
  logic                  time_init_r;
  logic                  sweep_pend_r, sweep_pend_n;
  logic [SEAT_W-1:0]     idx_r, idx_n;
  logic [2:0]            ptr_r, ptr_n;
  logic [1:0]            op_r;
  logic [SEAT_W-1:0]     op_seat_r;
  logic [2:0]            id_r;
  logic [NUM_SEATS-1:0]  busy_r, busy_n;
  logic [10:0]           expiry_r [NUM_SEATS];
  logic [NUM_REQ-1:0]    req_ready_r, req_ready_n;
  logic                  rsp_valid_r, rsp_valid_n;
  logic [2:0]            rsp_id_r, rsp_id_n;
  logic                  rsp_ok_r, rsp_ok_n;
  logic [SEAT_W-1:0]     rsp_seat_r, rsp_seat_n;
  logic [SEAT_W:0]       free_cnt_r;

  logic [4:0]            hour_s;
  logic [5:0]            min_s;
  logic                  time_legal_s;
  logic [10:0]           time_min_s;
  logic                  min_tick_s;
  logic [NUM_REQ-1:0]    rot_s;
  logic [2:0]            off_s;
  logic [3:0]            win_sum_s;
  logic [2:0]            win_idx_s;
  logic [NUM_REQ-1:0]    grant_vec_s;
  logic [1:0]            win_op_s;
  logic [SEAT_W-1:0]     win_seat_s;
  logic                  latch_s;
  logic                  seat_in_range_s;
  logic                  exec_ok_s, exec_set_s, exec_clr_s;
  logic [SEAT_W-1:0]     exec_seat_s;
  logic [SEAT_W-1:0]     fail_seat_s;
  logic                  exp_we_s;

  assign hour_s       = time_in[10:6];
  assign min_s        = time_in[5:0];
  assign time_legal_s = (hour_s <= 5'd23) && (min_s <= 6'd59);
  assign time_min_s   = 11'(hour_s) * 11'd60 + 11'(min_s);
  // The first legal reading after reset only seeds now_min; later changes request a sweep.
  assign min_tick_s   = time_legal_s && time_init_r && (time_min_s != now_min_r);

  // Wall-clock capture; out-of-range readings are dropped and now_min holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_min_r   <= 11'd0;
      time_init_r <= 1'b0;
    end else if (time_legal_s) begin
      now_min_r   <= time_min_s;
      time_init_r <= 1'b1;
    end
  end

  // Round-robin pick: rotate requests so ptr_r lands on bit 0, then take the lowest set bit.
  always_comb begin
    rot_s = NUM_REQ'({req_valid, req_valid} >> ptr_r);
    off_s = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off_s = rot_s[i] ? 3'(i) : off_s;
    win_sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    win_idx_s = (win_sum_s >= 4'(NUM_REQ)) ? 3'(win_sum_s - 4'(NUM_REQ)) : win_sum_s[2:0];
  end

  assign grant_vec_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign win_op_s        = 2'(req_op >> {win_idx_s, 1'b0});
  assign win_seat_s      = SEAT_W'(req_seat >> (int'(win_idx_s) * SEAT_W));
  assign seat_in_range_s = ({1'b0, op_seat_r} < (SEAT_W+1)'(NUM_SEATS));
  assign fail_seat_s     = (op_r == OP_ANY) ? '0 : op_seat_r;

`ifdef SEAT_ALLOC_AUTO_EN
  logic [SEAT_W-1:0] free_idx_s;
  logic              any_free_s;

  // Lowest-index free seat for the reserve-any op.
  always_comb begin
    free_idx_s = '0;
    for (int i = NUM_SEATS - 1; i >= 0; i--) free_idx_s = busy_r[i] ? free_idx_s : SEAT_W'(i);
  end

  assign any_free_s = ~&busy_r;
`endif

  // Outcome of the latched op against the current table.
  always_comb begin
    exec_ok_s   = 1'b0;
    exec_set_s  = 1'b0;
    exec_clr_s  = 1'b0;
    exec_seat_s = op_seat_r;
    case (op_r)
      OP_RES: begin
        if (seat_in_range_s && !busy_r[op_seat_r]) begin
          exec_ok_s  = 1'b1;
          exec_set_s = 1'b1;
        end else begin
          exec_ok_s  = 1'b0;
        end
      end
      OP_REL: begin
        if (seat_in_range_s && busy_r[op_seat_r]) begin
          exec_ok_s  = 1'b1;
          exec_clr_s = 1'b1;
        end else begin
          exec_ok_s  = 1'b0;
        end
      end
      OP_ANY: begin
`ifdef SEAT_ALLOC_AUTO_EN
        if (any_free_s) begin
          exec_ok_s   = 1'b1;
          exec_set_s  = 1'b1;
          exec_seat_s = free_idx_s;
        end else begin
          exec_seat_s = '0;
        end
`else
        exec_seat_s = '0;
`endif
      end
      default: exec_ok_s = 1'b0;
    endcase
  end

  // FSM next state, table update and response generation.
  always_comb begin
    state_n      = state_r;
    busy_n       = busy_r;
    sweep_pend_n = sweep_pend_r | min_tick_s;
    idx_n        = idx_r;
    ptr_n        = ptr_r;
    latch_s      = 1'b0;
    exp_we_s     = 1'b0;
    req_ready_n  = '0;
    rsp_valid_n  = 1'b0;
    rsp_ok_n     = 1'b0;
    rsp_id_n     = rsp_id_r;
    rsp_seat_n   = rsp_seat_r;
    if (rst_timer) begin
      // Daily reset wipes the table and any pending sweep; a running grant still finishes.
      busy_n       = '0;
      sweep_pend_n = 1'b0;
      case (state_r)
        IDLE:  state_n = IDLE;
        GRANT: state_n = EXEC;
        EXEC: begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_id_n    = id_r;
          rsp_seat_n  = fail_seat_s;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (sweep_pend_r) begin
            state_n      = SWEEP;
            idx_n        = '0;
            sweep_pend_n = min_tick_s;
          end else if (|req_valid) begin
            state_n     = GRANT;
            req_ready_n = grant_vec_s;
            ptr_n       = (win_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx_s + 3'd1;
            latch_s     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        GRANT: state_n = EXEC;
        EXEC: begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_id_n    = id_r;
          rsp_ok_n    = exec_ok_s;
          rsp_seat_n  = exec_seat_s;
          if (exec_set_s) begin
            busy_n[exec_seat_s] = 1'b1;
            exp_we_s            = 1'b1;
          end else if (exec_clr_s) begin
            busy_n[exec_seat_s] = 1'b0;
          end else begin
            busy_n = busy_r;
          end
        end
        SWEEP: begin
          if (busy_r[idx_r] && (expiry_r[idx_r] == now_min_r)) busy_n[idx_r] = 1'b0;
          else busy_n = busy_r;
          if (idx_r == LAST_SEAT) state_n = IDLE;
          else idx_n = idx_r + SEAT_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, table and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sweep_pend_r <= 1'b0;
      idx_r        <= '0;
      ptr_r        <= 3'd0;
      op_r         <= 2'b00;
      op_seat_r    <= '0;
      id_r         <= 3'd0;
      busy_r       <= '0;
      req_ready_r  <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 3'd0;
      rsp_ok_r     <= 1'b0;
      rsp_seat_r   <= '0;
      free_cnt_r   <= (SEAT_W+1)'(NUM_SEATS);
    end else begin
      state_r      <= state_n;
      sweep_pend_r <= sweep_pend_n;
      idx_r        <= idx_n;
      ptr_r        <= ptr_n;
      busy_r       <= busy_n;
      req_ready_r  <= req_ready_n;
      rsp_valid_r  <= rsp_valid_n;
      rsp_id_r     <= rsp_id_n;
      rsp_ok_r     <= rsp_ok_n;
      rsp_seat_r   <= rsp_seat_n;
      free_cnt_r   <= free_of(busy_n);
      if (latch_s) begin
        op_r      <= win_op_s;
        op_seat_r <= win_seat_s;
        id_r      <= win_idx_s;
      end
    end
  end

  // Expiry stamps; contents only matter while the matching busy bit is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEATS; i++) expiry_r[i] <= 11'd0;
    end else if (exp_we_s) begin
      expiry_r[exec_seat_s] <= expiry_of(now_min_r);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_ok    = rsp_ok_r;
  assign rsp_seat  = rsp_seat_r;
  assign seat_busy = busy_r;
  assign free_cnt  = free_cnt_r;

endmodule

// File: tb/tb_seat_alloc_sched.sv
// Directed bench for seat_alloc_sched: reset, reserve/release, round-robin, expiry sweep,
// daily reset during EXEC and the reserve-any op (expectation follows SEAT_ALLOC_AUTO_EN).
module tb_seat_alloc_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [15:0] req_seat;
  logic [3:0]  req_ready;
  logic [10:0] time_in;
  logic        rst_timer;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic        rsp_ok;
  logic [3:0]  rsp_seat;
  logic [15:0] seat_busy;
  logic [4:0]  free_cnt;

  int total = 0;
  int bad   = 0;

  seat_alloc_sched #(.NUM_REQ(4), .NUM_SEATS(16), .SEAT_W(4), .HOLD_MIN(120)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_seat(req_seat),
    .req_ready(req_ready), .time_in(time_in), .rst_timer(rst_timer), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_ok(rsp_ok), .rsp_seat(rsp_seat), .seat_busy(seat_busy),
    .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    req_valid = 4'h0;
    rst_timer = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One kiosk transaction; returns the response plus ready/response delays in cycles.
  task automatic do_req(input int k, input logic [1:0] op, input logic [3:0] seat,
                        output logic ok, output logic [3:0] rs, output logic [2:0] rid,
                        output int rdy_cyc, output int rsp_cyc, output logic got);
    got = 1'b0; ok = 1'b0; rs = 4'd0; rid = 3'd0; rdy_cyc = 0; rsp_cyc = 0;
    @(posedge clk); #1;
    req_op[2*k +: 2]   = op;
    req_seat[4*k +: 4] = seat;
    req_valid[k]       = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[k]) break;
      rdy_cyc++;
    end
    if (req_ready[k]) begin
      @(posedge clk); #1 req_valid[k] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        rsp_cyc++;
        if (rsp_valid) break;
      end
      if (rsp_valid) begin
        got = 1'b1; ok = rsp_ok; rs = rsp_seat; rid = rsp_id;
      end
    end else begin
      req_valid[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (seat_busy !== 16'h0000) begin bad++; $display("FAIL reset_busy got=%h exp=0000", seat_busy); end
    total++; if (free_cnt !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d exp=16", free_cnt); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_reserve();
    logic ok, got; logic [3:0] rs; logic [2:0] rid; int rc, pc;
    do_req(0, 2'b00, 4'd3, ok, rs, rid, rc, pc, got);
    total++; if (!got) begin bad++; $display("FAIL res_handshake got=timeout exp=response"); end
    total++; if (rc !== 1) begin bad++; $display("FAIL res_ready_lat got=%0d exp=1", rc); end
    total++; if (pc !== 2) begin bad++; $display("FAIL res_rsp_lat got=%0d exp=2", pc); end
    total++; if (ok !== 1'b1 || rs !== 4'd3 || rid !== 3'd0) begin
      bad++; $display("FAIL res_rsp got=ok%b seat%0d id%0d exp=ok1 seat3 id0", ok, rs, rid); end
    total++; if (seat_busy !== 16'h0008) begin bad++; $display("FAIL res_busy got=%h exp=0008", seat_busy); end
    total++; if (free_cnt !== 5'd15) begin bad++; $display("FAIL res_free got=%0d exp=15", free_cnt); end
  endtask

  task automatic test_reject();
    logic ok, got; logic [3:0] rs; logic [2:0] rid; int rc, pc;
    do_req(1, 2'b00, 4'd3, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b0 || rs !== 4'd3 || rid !== 3'd1) begin
      bad++; $display("FAIL dup_reserve got=ok%b seat%0d id%0d exp=ok0 seat3 id1", ok, rs, rid); end
    do_req(2, 2'b01, 4'd5, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b0 || rs !== 4'd5) begin
      bad++; $display("FAIL rel_free_seat got=ok%b seat%0d exp=ok0 seat5", ok, rs); end
    do_req(3, 2'b11, 4'd6, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b0 || seat_busy !== 16'h0008) begin
      bad++; $display("FAIL illegal_op got=ok%b busy%h exp=ok0 busy0008", ok, seat_busy); end
    do_req(0, 2'b01, 4'd3, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b1 || seat_busy !== 16'h0000 || free_cnt !== 5'd16) begin
      bad++; $display("FAIL release got=ok%b busy%h free%0d exp=ok1 busy0000 free16", ok, seat_busy, free_cnt); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int w;
    apply_reset();
    req_op    = 8'hFF;
    req_valid = 4'hF;
    for (int g = 0; g < 200 && n < 5; g++) begin
      @(negedge clk);
      if (req_ready !== 4'h0) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) w = i;
        total++; if ($countones(req_ready) != 1) begin
          bad++; $display("FAIL rr_onehot got=%b exp=one bit", req_ready); end
        total++; if (w != exp_order[n]) begin
          bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", n, w, exp_order[n]); end
        n++;
        @(posedge clk); #1 req_valid[w] = 1'b0;
        @(posedge clk); #1 req_valid[w] = 1'b1;
      end
    end
    req_valid = 4'h0;
    total++; if (n != 5) begin bad++; $display("FAIL rr_grants got=%0d exp=5", n); end
    req_op = 8'h00;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_expiry();
    logic ok, got; logic [3:0] rs; logic [2:0] rid; int rc, pc;
    @(posedge clk); #1 time_in = {5'd23, 6'd30};
    repeat (30) @(posedge clk);
    #1 time_in = {5'd24, 6'd0};
    repeat (3) @(posedge clk);
    do_req(2, 2'b00, 4'd7, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b1 || seat_busy !== 16'h0080) begin
      bad++; $display("FAIL exp_reserve got=ok%b busy%h exp=ok1 busy0080", ok, seat_busy); end
    @(posedge clk); #1 time_in = {5'd1, 6'd29};
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++; if (seat_busy[7] !== 1'b1) begin bad++; $display("FAIL exp_0129 got=%b exp=1", seat_busy[7]); end
    @(posedge clk); #1 time_in = {5'd1, 6'd30};
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++; if (seat_busy[7] !== 1'b0 || free_cnt !== 5'd16) begin
      bad++; $display("FAIL exp_0130 got=busy%b free%0d exp=busy0 free16", seat_busy[7], free_cnt); end
  endtask

  task automatic test_rst_exec();
    logic ok, got; logic [3:0] rs; logic [2:0] rid; int rc, pc;
    for (int s = 0; s < 10; s++) do_req(s % 4, 2'b00, 4'(s), ok, rs, rid, rc, pc, got);
    total++; if (seat_busy !== 16'h03FF || free_cnt !== 5'd6) begin
      bad++; $display("FAIL fill10 got=busy%h free%0d exp=busy03ff free6", seat_busy, free_cnt); end
    @(posedge clk); #1;
    req_op[3:2] = 2'b00; req_seat[7:4] = 4'd12; req_valid[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[1]) break;
    end
    total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL rst_grant got=%b exp=1", req_ready[1]); end
    @(posedge clk); #1 req_valid[1] = 1'b0; rst_timer = 1'b1;
    @(posedge clk); #1 rst_timer = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b0 || rsp_id !== 3'd1) begin
      bad++; $display("FAIL rst_rsp got=v%b ok%b id%0d exp=v1 ok0 id1", rsp_valid, rsp_ok, rsp_id); end
    total++; if (seat_busy !== 16'h0000 || free_cnt !== 5'd16) begin
      bad++; $display("FAIL rst_table got=busy%h free%0d exp=busy0000 free16", seat_busy, free_cnt); end
  endtask

  task automatic test_auto();
    logic ok, got; logic [3:0] rs; logic [2:0] rid; int rc, pc;
    do_req(3, 2'b00, 4'd0, ok, rs, rid, rc, pc, got);
    do_req(3, 2'b00, 4'd1, ok, rs, rid, rc, pc, got);
    do_req(2, 2'b10, 4'd9, ok, rs, rid, rc, pc, got);
`ifdef SEAT_ALLOC_AUTO_EN
    total++; if (ok !== 1'b1 || rs !== 4'd2 || seat_busy !== 16'h0007 || free_cnt !== 5'd13) begin
      bad++; $display("FAIL auto_pick got=ok%b seat%0d busy%h exp=ok1 seat2 busy0007", ok, rs, seat_busy); end
    for (int s = 3; s < 16; s++) do_req(s % 4, 2'b00, 4'(s), ok, rs, rid, rc, pc, got);
    do_req(1, 2'b10, 4'd9, ok, rs, rid, rc, pc, got);
    total++; if (ok !== 1'b0 || rs !== 4'd0 || free_cnt !== 5'd0) begin
      bad++; $display("FAIL auto_full got=ok%b seat%0d free%0d exp=ok0 seat0 free0", ok, rs, free_cnt); end
`else
    total++; if (ok !== 1'b0 || rs !== 4'd0 || seat_busy !== 16'h0003 || free_cnt !== 5'd14) begin
      bad++; $display("FAIL auto_off got=ok%b seat%0d busy%h exp=ok0 seat0 busy0003", ok, rs, seat_busy); end
`endif
  endtask

  initial begin
    req_valid = 4'h0;
    req_op    = 8'h00;
    req_seat  = 16'h0000;
    rst_timer = 1'b0;
    time_in   = {5'd9, 6'd0};
    rst_n     = 1'b0;
    test_reset();
    test_reserve();
    test_reject();
    test_round_robin();
    test_expiry();
    test_rst_exec();
    test_auto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
